// File: rtl/cla_pkg.sv
// Shared types and helpers for the CLA adder stream controller.
package cla_pkg;

  localparam int unsigned CLA_WIDTH = 32;
  localparam int unsigned TAG_W     = 4;

  typedef struct packed {
    logic [CLA_WIDTH-1:0] sum;
    logic                 carry;
    logic                 ovf;
    logic                 zero;
    logic [TAG_W-1:0]     tag;
  } cla_result_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic             a_msb;
    logic             b_msb;
  } cla_inflight_t;

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic sum_msb);
    return (a_msb == b_msb) && (sum_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla_result_fifo.sv
// Synchronous result FIFO; pointers carry one extra wrap bit so full/empty need no flag.
module cla_result_fifo
  import cla_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  cla_result_t            i_data,
  input  logic                   i_pop,
  output cla_result_t            o_data,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  cla_result_t r_mem [DEPTH];
  logic        w_pop;

  assign w_pop   = i_pop && !o_empty;
  assign o_count = r_wptr - r_rptr;
  assign o_empty = (o_count == '0);
  assign o_full  = (o_count == FULL_CNT);
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage is not reset: an entry is only visible once its write pointer has passed it.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/cla_add_stream_ctrl.sv
// Valid/ready wrapper around the external CLA adder: latency tracking, flag capture,
// result queueing and credit-based admission so backpressure never drops a result.
module cla_add_stream_ctrl
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH     = CLA_WIDTH,
  parameter int unsigned ADD_LAT   = 2,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  input  logic             in_carry_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic [WIDTH-1:0] add_a_o,
  output logic [WIDTH-1:0] add_b_o,
  output logic             add_carry_o,
  input  logic [WIDTH-1:0] add_sum_i,
  input  logic             add_carry_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_sum_o,
  output logic             out_carry_o,
  output logic             out_ovf_o,
  output logic             out_zero_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             busy_o
);

  localparam int unsigned CW = $clog2(OUT_DEPTH) + 1;
  localparam logic [CW-1:0] MAX_CRED = CW'(OUT_DEPTH);

  cla_inflight_t               r_pipe [ADD_LAT];
  logic [CW-1:0]               r_credits;
  logic                        w_accept;
  logic                        w_cap;
  logic                        w_pop;
  cla_inflight_t               w_stage0;
  cla_inflight_t               w_exit;
  cla_result_t                 w_res;
  cla_result_t                 w_head;
  logic                        w_empty;
  logic                        w_full;
  logic [$clog2(OUT_DEPTH):0]  w_fifo_cnt;

  // Credits count every result that is in flight or queued; ready depends only on that
  // register, so a pop reaches in_ready_o one cycle later and out_ready_i has no comb path here.
  assign in_ready_o = (r_credits < MAX_CRED);
  assign w_accept   = in_valid_i && in_ready_o;
  assign busy_o     = (r_credits != '0);

  assign add_a_o     = w_accept ? in_a_i : '0;
  assign add_b_o     = w_accept ? in_b_i : '0;
  assign add_carry_o = w_accept ? in_carry_i : 1'b0;

  assign w_exit = r_pipe[ADD_LAT-1];
  assign w_cap  = w_exit.valid;

  always_comb begin
    w_stage0       = '0;
    w_stage0.valid = w_accept;
    w_stage0.tag   = in_tag_i;
    w_stage0.a_msb = in_a_i[WIDTH-1];
    w_stage0.b_msb = in_b_i[WIDTH-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < ADD_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_stage0;
      for (int unsigned i = 1; i < ADD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_comb begin
    w_res       = '0;
    w_res.sum   = add_sum_i;
    w_res.carry = add_carry_i;
    w_res.ovf   = signed_ovf(w_exit.a_msb, w_exit.b_msb, add_sum_i[WIDTH-1]);
    w_res.zero  = (add_sum_i == '0);
    w_res.tag   = w_exit.tag;
  end

  cla_result_fifo #(
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_cap),
    .i_data  (w_res),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_fifo_cnt)
  );

  assign out_valid_o = !w_empty;
  assign w_pop       = out_valid_o && out_ready_i;
  assign out_sum_o   = out_valid_o ? w_head.sum   : '0;
  assign out_carry_o = out_valid_o ? w_head.carry : 1'b0;
  assign out_ovf_o   = out_valid_o ? w_head.ovf   : 1'b0;
  assign out_zero_o  = out_valid_o ? w_head.zero  : 1'b0;
  assign out_tag_o   = out_valid_o ? w_head.tag   : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_credits <= '0;
    end else begin
      r_credits <= r_credits + CW'(w_accept) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(w_cap && w_full && !w_pop));
      assert (CW'(w_fifo_cnt) <= r_credits);
    end
  end

endmodule

// File: tb/tb_cla_add_stream_ctrl.sv
// Scoreboard bench for cla_add_stream_ctrl with a behavioural ADD_LAT-cycle adder model.
module tb_cla_add_stream_ctrl;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned ADD_LAT   = 2;
  localparam int unsigned OUT_DEPTH = 4;

  typedef struct packed {
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
    logic        zero;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_a_i = '0;
  logic [31:0] in_b_i = '0;
  logic        in_carry_i = 1'b0;
  logic [3:0]  in_tag_i = '0;
  logic [31:0] add_a_o, add_b_o, add_sum_i;
  logic        add_carry_o, add_carry_i;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] out_sum_o;
  logic        out_carry_o, out_ovf_o, out_zero_o;
  logic [3:0]  out_tag_o;
  logic        busy_o;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_push  = 0;
  int   n_pop   = 0;

  always #5 clk = ~clk;

  cla_add_stream_ctrl #(
    .WIDTH     (WIDTH),
    .ADD_LAT   (ADD_LAT),
    .OUT_DEPTH (OUT_DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_a_i      (in_a_i),
    .in_b_i      (in_b_i),
    .in_carry_i  (in_carry_i),
    .in_tag_i    (in_tag_i),
    .add_a_o     (add_a_o),
    .add_b_o     (add_b_o),
    .add_carry_o (add_carry_o),
    .add_sum_i   (add_sum_i),
    .add_carry_i (add_carry_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_sum_o   (out_sum_o),
    .out_carry_o (out_carry_o),
    .out_ovf_o   (out_ovf_o),
    .out_zero_o  (out_zero_o),
    .out_tag_o   (out_tag_o),
    .busy_o      (busy_o)
  );

  // Behavioural adder: registers operands ADD_LAT times, sum is combinational from the last stage.
  logic [31:0] m_a [ADD_LAT];
  logic [31:0] m_b [ADD_LAT];
  logic        m_c [ADD_LAT];
  always @(posedge clk) begin
    m_a[0] <= add_a_o;
    m_b[0] <= add_b_o;
    m_c[0] <= add_carry_o;
    for (int i = 1; i < ADD_LAT; i++) begin
      m_a[i] <= m_a[i-1];
      m_b[i] <= m_b[i-1];
      m_c[i] <= m_c[i-1];
    end
  end
  assign {add_carry_i, add_sum_i} = {1'b0, m_a[ADD_LAT-1]} + {1'b0, m_b[ADD_LAT-1]}
                                  + {32'd0, m_c[ADD_LAT-1]};

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input logic [3:0] tag);
    exp_t        e;
    logic [32:0] s;
    s       = {1'b0, a} + {1'b0, b} + {32'd0, c};
    e.sum   = s[31:0];
    e.carry = s[32];
    e.ovf   = (a[31] == b[31]) && (s[31] != a[31]);
    e.zero  = (s[31:0] == 32'd0);
    e.tag   = tag;
    return e;
  endfunction

  // Monitor: samples on the falling edge; the push observed here is the accept of the next rising edge.
  exp_t got, prev;
  exp_t e_mon;
  logic stall_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_i) begin
      stall_prev = 1'b0;
    end else begin
      got = {out_sum_o, out_carry_o, out_ovf_o, out_zero_o, out_tag_o};
      if (stall_prev) begin
        n_tests++;
        if (out_valid_o !== 1'b1 || got !== prev) begin
          n_fail++;
          $display("FAIL hold_stable: valid=%0b out=%h required valid=1 out=%h",
                   out_valid_o, got, prev);
        end
      end
      if (out_valid_o && out_ready_i) begin
        n_tests++;
        n_pop++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: out=%h required no result", got);
        end else begin
          e_mon = q.pop_front();
          if (got !== e_mon) begin
            n_fail++;
            $display("FAIL result: sum=%h c=%0b ovf=%0b z=%0b tag=%0d required sum=%h c=%0b ovf=%0b z=%0b tag=%0d",
                     got.sum, got.carry, got.ovf, got.zero, got.tag,
                     e_mon.sum, e_mon.carry, e_mon.ovf, e_mon.zero, e_mon.tag);
          end
        end
      end
      if (in_valid_i && in_ready_o) begin
        q.push_back(model(in_a_i, in_b_i, in_carry_i, in_tag_i));
        n_push++;
      end
      stall_prev = out_valid_o && !out_ready_i;
      prev       = got;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c,
                      input logic [3:0] tag);
    bit ok;
    ok         = 1'b0;
    in_valid_i = 1'b1;
    in_a_i     = a;
    in_b_i     = b;
    in_carry_i = c;
    in_tag_i   = tag;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    step();
    in_valid_i = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready_o=0 for 200 cycles, required 1 (tag %0d)", tag);
    end
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain: pending=%0d busy=%0b required pending=0 busy=0", q.size(), busy_o);
    end
    step();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) step();
    rst_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({out_valid_o, busy_o, in_ready_o} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_ctrl: valid/busy/ready=%b required 001", {out_valid_o, busy_o, in_ready_o});
    end
    n_tests++;
    if ({add_a_o, add_b_o, add_carry_o, out_sum_o, out_tag_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: add_a=%h out_sum=%h tag=%0d required all 0", add_a_o, out_sum_o, out_tag_o);
    end
    step();
  endtask

  task automatic test_single();
    int lat;
    lat = -1;
    out_ready_i = 1'b1;
    send(32'h5, 32'h3, 1'b0, 4'd1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid_o) begin
        lat = k;
        break;
      end
    end
    n_tests++;
    if (lat != ADD_LAT + 1) begin
      n_fail++;
      $display("FAIL single_latency: %0d cycles required %0d", lat, ADD_LAT + 1);
    end
    n_tests++;
    if (out_sum_o !== 32'h8 || out_tag_o !== 4'd1 || {out_carry_o, out_ovf_o, out_zero_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL single_value: sum=%h tag=%0d cvz=%b required sum=00000008 tag=1 cvz=000",
               out_sum_o, out_tag_o, {out_carry_o, out_ovf_o, out_zero_o});
    end
    step();
    wait_drain();
  endtask

  task automatic test_flags();
    logic [31:0] exp_sum [3];
    logic [2:0]  exp_cvz [3];
    exp_sum[0] = 32'h0000_0000; exp_cvz[0] = 3'b101;
    exp_sum[1] = 32'h8000_0000; exp_cvz[1] = 3'b010;
    exp_sum[2] = 32'h0000_0000; exp_cvz[2] = 3'b111;
    out_ready_i = 1'b0;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'd2);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4'd3);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 4'd4);
    repeat (ADD_LAT + 3) step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (!out_valid_o || out_sum_o !== exp_sum[i] || out_tag_o !== 4'(i + 2) ||
          {out_carry_o, out_ovf_o, out_zero_o} !== exp_cvz[i]) begin
        n_fail++;
        $display("FAIL flags_%0d: valid=%0b sum=%h cvz=%b tag=%0d required valid=1 sum=%h cvz=%b tag=%0d",
                 i, out_valid_o, out_sum_o, {out_carry_o, out_ovf_o, out_zero_o}, out_tag_o,
                 exp_sum[i], exp_cvz[i], i + 2);
      end
      step();
      out_ready_i = 1'b1;
      @(negedge clk);
      step();
      out_ready_i = 1'b0;
    end
    out_ready_i = 1'b1;
    wait_drain();
  endtask

  task automatic test_backpressure();
    int acc;
    bit rdy;
    acc = 0;
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in_a_i     = $urandom;
      in_b_i     = $urandom;
      in_carry_i = 1'($urandom_range(0, 1));
      in_tag_i   = 4'(acc);
      @(negedge clk);
      rdy = in_ready_o;
      step();
      if (rdy) acc++;
    end
    in_valid_i = 1'b0;
    n_tests++;
    if (acc != OUT_DEPTH || in_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accepts: accepts=%0d ready=%0b required accepts=%0d ready=0", acc, in_ready_o, OUT_DEPTH);
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 || out_tag_o !== 4'd0) begin
      n_fail++;
      $display("FAIL bp_first_pop: ready=%0b valid=%0b tag=%0d required ready=0 valid=1 tag=0",
               in_ready_o, out_valid_o, out_tag_o);
    end
    @(negedge clk);
    n_tests++;
    if (in_ready_o !== 1'b1 || out_tag_o !== 4'd1) begin
      n_fail++;
      $display("FAIL bp_credit_return: ready=%0b tag=%0d required ready=1 tag=1", in_ready_o, out_tag_o);
    end
    step();
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int stalls;
    int bad;
    bit seen;
    stalls = 0;
    bad    = 0;
    seen   = 1'b0;
    out_ready_i = 1'b1;
    fork
      begin
        in_valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
          in_a_i     = $urandom;
          in_b_i     = $urandom;
          in_carry_i = 1'($urandom_range(0, 1));
          in_tag_i   = 4'(i);
          @(negedge clk);
          if (!in_ready_o) stalls++;
          step();
        end
        in_valid_i = 1'b0;
      end
      begin
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (out_valid_o) begin
            seen = 1'b1;
            break;
          end
        end
        if (seen) begin
          for (int j = 0; j < 16; j++) begin
            if (j > 0) @(negedge clk);
            if (!out_valid_o || out_tag_o !== 4'(j)) bad++;
          end
        end
      end
    join
    n_tests++;
    if (stalls != 0) begin
      n_fail++;
      $display("FAIL b2b_accept: stalls=%0d required 0", stalls);
    end
    n_tests++;
    if (!seen || bad != 0) begin
      n_fail++;
      $display("FAIL b2b_output: seen=%0b gaps_or_misorders=%0d required seen=1 gaps=0", seen, bad);
    end
    wait_drain();
  endtask

  task automatic test_reset_midflight();
    int stale;
    stale = 0;
    out_ready_i = 1'b1;
    send(32'h1111_1111, 32'h2222_2222, 1'b0, 4'd5);
    send(32'h3333_3333, 32'h4444_4444, 1'b1, 4'd6);
    send(32'h5555_5555, 32'h6666_6666, 1'b0, 4'd7);
    rst_i = 1'b1;
    q.delete();
    step();
    rst_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({out_valid_o, busy_o, in_ready_o} !== 3'b001) begin
      n_fail++;
      $display("FAIL midreset_state: valid/busy/ready=%b required 001", {out_valid_o, busy_o, in_ready_o});
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid_o || busy_o) stale++;
    end
    n_tests++;
    if (stale != 0) begin
      n_fail++;
      $display("FAIL midreset_stale: %0d cycles with valid/busy required 0", stale);
    end
    step();
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    int  push0;
    int  pop0;
    bit  done;
    push0 = n_push;
    pop0  = n_pop;
    done  = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid_i = 1'b0;
            step();
          end
          send(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), 4'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready_i = 1'($urandom_range(0, 1));
          step();
        end
        out_ready_i = 1'b1;
      end
    join
    wait_drain();
    n_tests++;
    if (n_push - push0 != 1000 || n_pop - pop0 != 1000) begin
      n_fail++;
      $display("FAIL random_count: accepted=%0d delivered=%0d required 1000/1000",
               n_push - push0, n_pop - pop0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_flags();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/cla_add_stream_ctrl.md
Name: cla_add_stream_ctrl

Overview:
- Stream front/back end for the 32-bit CLA adder stage. It sits directly upstream and downstream of that stage.
- Accepts operand transactions on a valid/ready input, drives the adder operand/carry inputs and tracks results in flight through the adder pipeline with a valid shift register.
- Captures each sum/carry with computed flags into a result FIFO and presents it on a valid/ready output.
- Credit-based admission: no result is ever dropped when the output backpressures.

Parameters:
- WIDTH, 32, operand/sum width; must match the adder.
- ADD_LAT, 2, adder latency in clk_i cycles from operand drive to sum/carry valid; legal range 1..8.
- OUT_DEPTH, 4, result FIFO entries; must be >= ADD_LAT; power of two.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- in_valid_i  in  1  operand transaction valid
- in_ready_o  out  1  block can accept a transaction this cycle
- in_a_i  in  WIDTH  operand A
- in_b_i  in  WIDTH  operand B
- in_carry_i  in  1  carry-in
- in_tag_i  in  4  user tag, returned with the result
- add_a_o  out  WIDTH  to adder a_i
- add_b_o  out  WIDTH  to adder b_i
- add_carry_o  out  1  to adder carry_i
- add_sum_i  in  WIDTH  from adder sum_o
- add_carry_i  in  1  from adder carry_o
- out_valid_o  out  1  result available
- out_ready_i  in  1  consumer accepts result
- out_sum_o  out  WIDTH  sum
- out_carry_o  out  1  unsigned carry-out
- out_ovf_o  out  1  signed overflow
- out_zero_o  out  1  sum == 0
- out_tag_o  out  4  tag of this result
- busy_o  out  1  any transaction in flight or queued

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - all outputs 0, except in_ready_o, which is 1 in the first cycle after reset;
  - FIFO empty, in-flight pipe cleared, credit count 0.
- Accept:
  - A transaction is accepted when in_valid_i && in_ready_o.
  - add_a_o/add_b_o/add_carry_o are combinational pass-throughs of in_a_i/in_b_i/in_carry_i when accepting, else hold 0.
- In-flight tracking:
  - Shift register of ADD_LAT stages, each holding {valid, tag, a[WIDTH-1], b[WIDTH-1]}.
  - Stage 0 loads on accept.
  - The sum for a transaction is sampled from add_sum_i/add_carry_i in the cycle its entry exits stage ADD_LAT-1.
- Credits:
  - occupancy = FIFO count + valid in-flight entries.
  - in_ready_o = occupancy < OUT_DEPTH, computed from registered state only.
  - A same-cycle output pop does NOT free a credit until the next cycle. This avoids a comb path from out_ready_i to in_ready_o.
- Flags, computed at capture:
  - ovf = (a_msb == b_msb) && (sum_msb != a_msb);
  - zero = (sum == 0);
  - carry = add_carry_i.
- FIFO:
  - OUT_DEPTH entries of {sum, carry, ovf, zero, tag}; write on capture, pop on out_valid_o && out_ready_i.
  - Read/write pointers are log2(OUT_DEPTH)+1 bits and wrap naturally.
  - out_* is driven from the head entry; out_valid_o = !empty.
  - Push and pop in the same cycle: count unchanged, both pointers advance. This is legal when full (the pop frees the slot being written only by pointer order; the credit scheme guarantees a capture never targets a full FIFO).
  - Full with no pop never coincides with a capture; an assertion checks this.
- Ordering: results leave in acceptance order. Throughput is 1 transaction/cycle when out_ready_i is held high.
- Flow: out_valid_o must stay asserted and out_* stable until the pop occurs.
- busy_o = occupancy != 0, registered.
- Reset mid-operation:
  - in-flight and queued results are discarded; no output valid in the cycle after reset.
  - Adder outputs that arrive afterwards are ignored because the in-flight valids are cleared.
- Ready/valid independence: in_valid_i may drop without acceptance. Data is only sampled on acceptance.

Decomposition:
- Package cla_pkg:
  - CLA_WIDTH = 32;
  - typedef cla_result_t {sum, carry, ovf, zero, tag};
  - typedef cla_inflight_t {valid, tag, a_msb, b_msb}.
- One sub-module: cla_result_fifo (parameterised sync FIFO of cla_result_t, depth OUT_DEPTH, count output).
- Credit logic and the latency pipe stay in the top.

Test Plan:
- Single add: a=0x0000_0005, b=0x0000_0003, cin=0, tag=1 -> after ADD_LAT cycles plus FIFO write, out_sum=0x8, carry=0, ovf=0, zero=0, tag=1.
- Wrap: a=0xFFFF_FFFF, b=0x0000_0001, cin=0 -> sum=0, carry=1, zero=1, ovf=0. Signed overflow: a=0x7FFF_FFFF, b=1 -> sum=0x8000_0000, ovf=1, carry=0.
- Backpressure:
  - out_ready_i=0, in_valid_i held 1 -> exactly OUT_DEPTH (4) accepts, then in_ready_o=0.
  - Release out_ready_i -> 4 results in order (tags 0..3), then in_ready_o returns 1 one cycle after the first pop.
- Streaming: 16 back-to-back transactions with out_ready_i=1 -> one accept/cycle, results every cycle after the initial latency, tags 0..15 in order, no gaps.
- Reset mid-flight: accept 3 transactions, assert rst_i for 1 cycle while the adder is still producing -> out_valid_o=0, busy_o=0, in_ready_o=1 afterwards; no stale result emerges.
- Random out_ready_i toggling, 1000 transactions vs. reference model -> all sums/flags/tags match, none lost or duplicated.
